// File: rtl/mic_dac_bridge_pkg.sv
// Shared types and constants for the mic-to-DAC bridge: FSM states, routing modes,
// and width-generic midscale/saturation helpers.
package mic_dac_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_CH0  = 2'd0;
  localparam logic [1:0] MODE_CH1  = 2'd1;
  localparam logic [1:0] MODE_BOTH = 2'd2;
  localparam logic [1:0] MODE_CPL  = 2'd3;

  localparam int MAX_GAIN_SHIFT = 3;

  function automatic int midscale(input int w);
    return 1 << (w - 1);
  endfunction

  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/mic_dac_bridge_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; a push into a full FIFO is
// dropped unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign pop_data  = r_mem[r_rd_ptr];
  assign level     = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mic_dac_bridge.sv
// Mic sample -> gain/saturate -> FIFO -> DAC handshake FSM with channel routing.
// Define MIC_DAC_BRIDGE_AVG_EN to average blocks of 4 gained samples before the FIFO.
module mic_dac_bridge
  import mic_dac_bridge_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 8,
  parameter int ACK_TMO = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic [1:0]              mode,
  input  logic [1:0]              gain,
  input  logic                    dac_busy,
  output logic [DATA_W-1:0]       dac_data0,
  output logic [DATA_W-1:0]       dac_data1,
  output logic                    dac_update,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int SW = DATA_W + MAX_GAIN_SHIFT + 1;
  localparam int TW = $clog2(ACK_TMO + 1);
  localparam logic signed [SW-1:0] C_MID   = SW'(midscale(DATA_W));
  localparam logic signed [SW-1:0] C_HI    = SW'(sat_hi(DATA_W));
  localparam logic signed [SW-1:0] C_LO    = SW'(sat_lo(DATA_W));
  localparam logic [DATA_W-1:0]    C_MID_U = DATA_W'(midscale(DATA_W));

  logic signed [SW-1:0] w_diff, w_shift, w_sat, w_sum;
  logic [DATA_W-1:0]    r_g_data;
  logic                 r_g_valid;
  logic                 w_push;
  logic [DATA_W-1:0]    w_push_data;
  logic [DATA_W-1:0]    w_head;
  logic                 w_full, w_empty, w_pop;
  logic                 r_overflow;
  logic [DATA_W-1:0]    r_dac0, r_dac1;
  state_t               r_state, w_state_next;
  logic [TW-1:0]        r_tmo, w_tmo_next;

  assign w_diff  = $signed({{(SW-DATA_W){1'b0}}, in_data}) - C_MID;
  assign w_shift = w_diff <<< gain;
  assign w_sat   = (w_shift > C_HI) ? C_HI : ((w_shift < C_LO) ? C_LO : w_shift);
  assign w_sum   = w_sat + C_MID;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_g_data  <= C_MID_U;
      r_g_valid <= 1'b0;
    end else begin
      r_g_data  <= w_sum[DATA_W-1:0];
      r_g_valid <= in_valid && en;
    end
  end

`ifdef MIC_DAC_BRIDGE_AVG_EN
  logic [DATA_W+1:0] r_acc;
  logic [1:0]        r_cnt;
  logic [DATA_W+1:0] w_acc_sum;

  assign w_acc_sum   = r_acc + (DATA_W+2)'(r_g_data);
  assign w_push      = r_g_valid && en && (r_cnt == 2'd3);
  assign w_push_data = w_acc_sum[DATA_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (!en) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_g_valid) begin
      r_acc <= (r_cnt == 2'd3) ? '0 : w_acc_sum;
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_push      = r_g_valid;
  assign w_push_data = r_g_data;
`endif

  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_tmo   <= '0;
    end else begin
      r_state <= w_state_next;
      r_tmo   <= w_tmo_next;
    end
  end

  // The ACK timer counts idle ACK cycles; expiry drops the in-flight sample.
  always_comb begin
    w_state_next = r_state;
    w_tmo_next   = r_tmo;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !dac_busy) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_tmo_next   = '0;
        w_state_next = ST_ACK;
      end
      ST_ACK: begin
        if (dac_busy)                         w_state_next = ST_DONE;
        else if (r_tmo == TW'(ACK_TMO - 1))   w_state_next = ST_IDLE;
        else                                  w_tmo_next   = r_tmo + 1'b1;
      end
      ST_DONE: begin
        if (!dac_busy) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dac0 <= C_MID_U;
      r_dac1 <= C_MID_U;
    end else if (w_pop) begin
      case (mode)
        MODE_CH0:  r_dac0 <= w_head;
        MODE_CH1:  r_dac1 <= w_head;
        MODE_BOTH: begin
          r_dac0 <= w_head;
          r_dac1 <= w_head;
        end
        MODE_CPL: begin
          r_dac0 <= w_head;
          r_dac1 <= ~w_head;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_overflow <= 1'b0;
    else if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
  end

  assign dac_data0  = r_dac0;
  assign dac_data1  = r_dac1;
  assign dac_update = (r_state == ST_ISSUE);
  assign overflow   = r_overflow;

endmodule

// File: doc/mic_dac_bridge.md
MIC_DAC_BRIDGE -- requirements
Module: mic_dac_bridge

Interface
REQ-001 Parameter DATA_W, default 12, sample width for mic input and both DAC channels.
REQ-002 Parameter DEPTH, default 8, FIFO depth in samples; a power of two, at least 2.
REQ-003 Parameter ACK_TMO, default 15, number of cycles to wait for DAC busy before abandoning an update.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  accept enable; when low, incoming samples are discarded and the FIFO keeps draining.
REQ-007 in_data  input  DATA_W  unsigned mic sample, midscale 2^(DATA_W-1).
REQ-008 in_valid  input  1  one-cycle pulse qualifying in_data.
REQ-009 mode  input  2  channel routing: 0=ch0 only, 1=ch1 only, 2=both equal, 3=ch1 is the complement of ch0.
REQ-010 gain  input  2  left-shift amount applied about midscale.
REQ-011 dac_busy  input  1  high while the DAC serialises a frame.
REQ-012 dac_data0, dac_data1  output  DATA_W each  channel words presented to the DAC.
REQ-013 dac_update  output  1  one-cycle pulse requesting a DAC frame.
REQ-014 overflow  output  1  sticky flag, set on a dropped sample.
REQ-015 level  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-016 Gain path: d = in_data - 2^(DATA_W-1) (signed); s = d << gain; saturate s to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; add midscale back; result is registered with 1-cycle latency, then pushed into the FIFO.
REQ-017 A push occurs only when en=1 at the in_valid cycle; with en=0 the sample is ignored and overflow is unchanged.
REQ-018 Push while full with no pop in the same cycle: the sample is dropped, FIFO unchanged, overflow set to 1.
REQ-019 Push and pop in the same cycle while full: both are performed and level is unchanged.
REQ-020 Pop never occurs while empty; read and write pointers wrap modulo DEPTH.
REQ-021 Output FSM has states IDLE, ISSUE, ACK and DONE.
REQ-022 IDLE->ISSUE when level>0 and dac_busy=0; the FIFO head is popped and routed to the dac_data registers.
REQ-023 In ISSUE, dac_update=1 for exactly one cycle, then the FSM goes to ACK.
REQ-024 ACK->DONE on dac_busy=1; ACK->IDLE after ACK_TMO cycles without busy, and the popped sample is lost.
REQ-025 DONE->IDLE on dac_busy=0.
REQ-026 Routing: mode 0 sets ch0=v and holds ch1; mode 1 sets ch1=v and holds ch0; mode 2 sets both to v; mode 3 sets ch0=v and ch1=(2^DATA_W-1)-v.
REQ-027 mode and gain are sampled at their point of use; a change affects only subsequent samples.
REQ-028 dac_data0/1 change only on the IDLE->ISSUE transition and are stable while dac_update is high.
REQ-029 overflow clears only on reset.

Reset
REQ-030 rst low immediately sets the FIFO empty, level=0, the FSM to IDLE, dac_update=0, overflow=0, and dac_data0/1 to midscale.
REQ-031 Reset asserted mid-frame abandons the frame; after release the block waits for dac_busy=0 in IDLE before issuing.

Configuration
REQ-032 Macro MIC_DAC_BRIDGE_AVG_EN, when defined, inserts a block averager between the gain path and the FIFO.
REQ-033 The averager sums 4 gained samples into a DATA_W+2 accumulator, pushes sum>>2, then clears; only every 4th accepted sample pushes.
REQ-034 The averager accumulator and count clear on reset and whenever en=0.
REQ-035 Without the macro, every accepted sample is pushed with no averaging logic present.

Structure
REQ-036 A shared package holds the FSM state enum, the mode encodings and the midscale/saturation constants.
REQ-037 The FIFO is a separate sub-module, sync_fifo, with push/pop/full/empty/level ports.

Verification
REQ-038 Unity gain: gain=0, mode=2, in_data=0x9A3 pulse -> one dac_update; ch0=ch1=0x9A3.
REQ-039 Saturation: gain=3, in_data=0xC00 -> output 0xFFF; in_data=0x100 -> output 0x000.
REQ-040 Complement: mode=3, in_data=0x300 -> ch0=0x300, ch1=0xCFF.
REQ-041 Full FIFO: dac_busy held high, 9 samples with DEPTH=8 -> level=8, overflow=1, the first 8 later emerge in order.
REQ-042 ACK timeout: dac_busy stuck low -> dac_update, 15 cycles later back in IDLE, next sample issued.
REQ-043 Reset in DONE with 3 queued -> level=0, dac_update never pulses, outputs 0x800.
